sec_lectura_rtc: RTL and testbench

SEC_LECTURA_RTC -- requirements
Module: sec_lectura_rtc

---
 rtl/sec_lectura_rtc.sv | 194 +++++++++++++++++++
 tb/tb_sec_lectura_rtc.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sec_lectura_rtc.sv
// sec_lectura_rtc: sweeps the ten RTC time/date registers over a multiplexed
// AD bus (address phase, idle gap, read strobe) and writes each byte it reads
// into local memory. Every output is driven straight from a flop.
//
// Bus handshake: there is no valid/ready pair. cs_n low with wr_n low and
// a_d=0 puts the register address on the bus (bus_oe=1). cs_n low with rd_n
// low and a_d=1 lets the RTC drive bus_in. bus_in is sampled on the clock
// edge that ends the last read cycle. mem_wr is high for exactly one cycle
// and qualifies mem_data and addr_rtc.
module sec_lectura_rtc #(
   parameter int T_ADDR = 4,
   parameter int T_GAP  = 2,
   parameter int T_RD   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [7:0] addr_rtc,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic       a_d,
   output logic       bus_oe,
   output logic [7:0] bus_out,
   input  logic [7:0] bus_in,
   output logic       mem_wr,
   output logic [7:0] mem_data,
   output logic [2:0] dbg_state
);

   // A phase length of 0 is treated as 1 so that no phase is ever skipped.
   localparam logic [7:0] TA_L = (T_ADDR < 1) ? 8'd1 : 8'(T_ADDR);
   localparam logic [7:0] TG_L = (T_GAP  < 1) ? 8'd1 : 8'(T_GAP);
   localparam logic [7:0] TR_L = (T_RD   < 1) ? 8'd1 : 8'(T_RD);
   localparam logic [3:0] LAST_IDX = 4'd9;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_GAP   = 3'd2,
      S_READ  = 3'd3,
      S_STORE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t     state_q;
   logic [3:0] idx_q;
   logic [7:0] cnt_q;
   logic       busy_q, done_q, cs_n_q, rd_n_q, wr_n_q, a_d_q, bus_oe_q, mem_wr_q;
   logic [7:0] addr_q, bus_out_q, mem_data_q;

   logic [3:0] idx_d;
   logic [7:0] addr_d;

   // Register address for a sweep index; FFh is the "no register" code.
   function automatic logic [7:0] rtc_addr(input logic [3:0] i);
      logic [7:0] a;
      case (i)
         4'd0:    a = 8'h21;
         4'd1:    a = 8'h22;
         4'd2:    a = 8'h23;
         4'd3:    a = 8'h24;
         4'd4:    a = 8'h25;
         4'd5:    a = 8'h26;
         4'd6:    a = 8'h27;
         4'd7:    a = 8'h41;
         4'd8:    a = 8'h42;
         4'd9:    a = 8'h43;
         default: a = 8'hFF;
      endcase
      return a;
   endfunction

   // Index and address of the register visited after the current STORE.
   always_comb begin
      idx_d  = idx_q + 4'd1;
      addr_d = rtc_addr(idx_d);
   end

   // Sweep FSM; outputs are loaded for the state being entered.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         idx_q      <= 4'd0;
         cnt_q      <= 8'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         rd_n_q     <= 1'b1;
         wr_n_q     <= 1'b1;
         a_d_q      <= 1'b1;
         bus_oe_q   <= 1'b0;
         bus_out_q  <= 8'h00;
         addr_q     <= 8'hFF;
         mem_wr_q   <= 1'b0;
         mem_data_q <= 8'h00;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q   <= S_ADDR;
                  idx_q     <= 4'd0;
                  cnt_q     <= 8'd0;
                  busy_q    <= 1'b1;
                  addr_q    <= rtc_addr(4'd0);
                  bus_out_q <= rtc_addr(4'd0);
                  cs_n_q    <= 1'b0;
                  wr_n_q    <= 1'b0;
                  a_d_q     <= 1'b0;
                  bus_oe_q  <= 1'b1;
               end
            end
            S_ADDR: begin
               if (cnt_q == TA_L - 8'd1) begin
                  state_q   <= S_GAP;
                  cnt_q     <= 8'd0;
                  cs_n_q    <= 1'b1;
                  wr_n_q    <= 1'b1;
                  a_d_q     <= 1'b1;
                  bus_oe_q  <= 1'b0;
                  bus_out_q <= 8'h00;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_GAP: begin
               if (cnt_q == TG_L - 8'd1) begin
                  state_q <= S_READ;
                  cnt_q   <= 8'd0;
                  cs_n_q  <= 1'b0;
                  rd_n_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_READ: begin
               if (cnt_q == TR_L - 8'd1) begin
                  state_q    <= S_STORE;
                  cnt_q      <= 8'd0;
                  cs_n_q     <= 1'b1;
                  rd_n_q     <= 1'b1;
                  mem_wr_q   <= 1'b1;
                  mem_data_q <= bus_in;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_STORE: begin
               mem_wr_q <= 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_q <= S_DONE;
                  idx_q   <= 4'd0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  addr_q  <= 8'hFF;
               end else begin
                  state_q   <= S_ADDR;
                  idx_q     <= idx_d;
                  addr_q    <= addr_d;
                  bus_out_q <= addr_d;
                  cs_n_q    <= 1'b0;
                  wr_n_q    <= 1'b0;
                  a_d_q     <= 1'b0;
                  bus_oe_q  <= 1'b1;
               end
            end
            S_DONE: begin
               // start is deliberately not looked at here: no queued sweeps.
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign addr_rtc  = addr_q;
   assign cs_n      = cs_n_q;
   assign rd_n      = rd_n_q;
   assign wr_n      = wr_n_q;
   assign a_d       = a_d_q;
   assign bus_oe    = bus_oe_q;
   assign bus_out   = bus_out_q;
   assign mem_wr    = mem_wr_q;
   assign mem_data  = mem_data_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sec_lectura_rtc.sv
// Directed bench for sec_lectura_rtc: a default-timing instance and a
// minimum-timing instance (T_ADDR=0, T_GAP=1, T_RD=1) share clock and reset.
// Expected outputs come from a per-cycle phase model keyed on the cycle
// count since start was sampled (cycle 1 = first ADDR cycle).
module tb_sec_lectura_rtc;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       start, start2;
   logic       ovr_en;
   logic [7:0] ovr_val;

   // DUT 1 (defaults)
   logic       busy1, done1, cs_n1, rd_n1, wr_n1, a_d1, bus_oe1, mem_wr1;
   logic [7:0] addr1, bus_out1, bus_in1, mem_data1;
   logic [2:0] dbg1;
   // DUT 2 (minimum timing)
   logic       busy2, done2, cs_n2, rd_n2, wr_n2, a_d2, bus_oe2, mem_wr2;
   logic [7:0] addr2, bus_out2, bus_in2, mem_data2;
   logic [2:0] dbg2;

   logic [7:0] tbl [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                            8'h26, 8'h27, 8'h41, 8'h42, 8'h43};

   int checks = 0;
   int errors = 0;

   // RTC model: register at sweep index i returns 10h+i.
   function automatic logic [7:0] rtc_data(input logic [7:0] a);
      logic [7:0] d;
      d = 8'h00;
      for (int i = 0; i < 10; i++) if (tbl[i] == a) d = 8'h10 + 8'(i);
      return d;
   endfunction

   assign bus_in1 = ovr_en ? ovr_val : rtc_data(addr1);
   assign bus_in2 = rtc_data(addr2);

   sec_lectura_rtc u_dut1 (
      .clk(clk), .reset(reset), .start(start), .busy(busy1), .done(done1),
      .addr_rtc(addr1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1), .a_d(a_d1),
      .bus_oe(bus_oe1), .bus_out(bus_out1), .bus_in(bus_in1), .mem_wr(mem_wr1),
      .mem_data(mem_data1), .dbg_state(dbg1)
   );

   sec_lectura_rtc #(.T_ADDR(0), .T_GAP(1), .T_RD(1)) u_dut2 (
      .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
      .addr_rtc(addr2), .cs_n(cs_n2), .rd_n(rd_n2), .wr_n(wr_n2), .a_d(a_d2),
      .bus_oe(bus_oe2), .bus_out(bus_out2), .bus_in(bus_in2), .mem_wr(mem_wr2),
      .mem_data(mem_data2), .dbg_state(dbg2)
   );

   // Observation vectors: {busy,done,cs_n,rd_n,wr_n,a_d,bus_oe,mem_wr,addr,bus_out}
   logic [23:0] v1, v2;
   assign v1 = {busy1, done1, cs_n1, rd_n1, wr_n1, a_d1, bus_oe1, mem_wr1, addr1, bus_out1};
   assign v2 = {busy2, done2, cs_n2, rd_n2, wr_n2, a_d2, bus_oe2, mem_wr2, addr2, bus_out2};

   // ---------------- reference model ----------------
   // c = 0 or past the sweep means IDLE; ta/tg/tr are effective phase lengths.
   function automatic logic [23:0] exp_vec(input int c, input int ta, input int tg, input int tr);
      int per, r, p;
      logic bz, dn, cs, rd, wr, ad, oe, mw;
      logic [7:0] a8, bo;
      per = ta + tg + tr + 1;
      bz = 0; dn = 0; cs = 1; rd = 1; wr = 1; ad = 1; oe = 0; mw = 0;
      a8 = 8'hFF; bo = 8'h00;
      if (c >= 1 && c <= 10 * per) begin
         r = (c - 1) / per;
         p = (c - 1) % per;
         bz = 1;
         a8 = tbl[r];
         if (p < ta) begin
            cs = 0; wr = 0; ad = 0; oe = 1; bo = tbl[r];
         end else if (p < ta + tg) begin
            cs = 1;
         end else if (p < ta + tg + tr) begin
            cs = 0; rd = 0;
         end else begin
            mw = 1;
         end
      end else if (c == 10 * per + 1) begin
         dn = 1;
      end
      return {bz, dn, cs, rd, wr, ad, oe, mw, a8, bo};
   endfunction

   function automatic logic [7:0] exp_data(input int c, input int per);
      return 8'h10 + 8'((c - 1) / per);
   endfunction

   // ---------------- scoreboard helpers ----------------
   task automatic chk_vec(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      logic [23:0] o;
      o = obs;
      if (!exp[17]) o[7:0] = 8'h00;  // bus_out only meaningful while driven
      checks++;
      assert (o === exp) else begin
         errors++;
         $error("FAIL %s obs=%06h exp=%06h", tag, o, exp);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int mw1, mw2, dn1, dn2;
      logic [23:0] e;
      reset = 1'b0; start = 1'b1; start2 = 1'b1; ovr_en = 1'b0; ovr_val = 8'h00;

      // Reset with start asserted: reset values, start ignored.
      repeat (3) @(negedge clk);
      chk_vec("reset1", v1, exp_vec(0, 4, 2, 4));
      chk_vec("reset2", v2, exp_vec(0, 1, 1, 1));
      chk("reset_mdata1", {24'd0, mem_data1}, 32'h00);
      reset = 1'b1; start = 1'b0; start2 = 1'b0;
      repeat (2) @(negedge clk);
      chk_vec("post_rel1", v1, exp_vec(0, 4, 2, 4));
      chk_vec("post_rel2", v2, exp_vec(0, 1, 1, 1));

      // Full sweep on both instances; stray starts mid-sweep and in DONE.
      start = 1'b1; start2 = 1'b1;
      @(negedge clk);
      mw1 = 0; mw2 = 0; dn1 = 0; dn2 = 0;
      for (int c = 1; c <= 114; c++) begin
         e = exp_vec(c, 4, 2, 4);
         chk_vec($sformatf("sweep1 c=%0d", c), v1, e);
         if (e[16]) chk($sformatf("sweep1_data c=%0d", c), {24'd0, mem_data1}, {24'd0, exp_data(c, 11)});
         e = exp_vec(c, 1, 1, 1);
         chk_vec($sformatf("sweep2 c=%0d", c), v2, e);
         if (e[16]) chk($sformatf("sweep2_data c=%0d", c), {24'd0, mem_data2}, {24'd0, exp_data(c, 4)});
         mw1 += int'(mem_wr1); mw2 += int'(mem_wr2);
         dn1 += int'(done1);   dn2 += int'(done2);
         start  = (c >= 50 && c <= 52) || c == 111;
         start2 = (c >= 20 && c <= 22) || c == 41;
         @(negedge clk);
      end
      start = 1'b0; start2 = 1'b0;
      chk("sweep1_mem_wr_count", mw1, 10);
      chk("sweep2_mem_wr_count", mw2, 10);
      chk("sweep1_done_count", dn1, 1);
      chk("sweep2_done_count", dn2, 1);

      // Late-changing bus_in, then reset during READ of index 7 (41h).
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 85; c++) begin
         e = exp_vec(c, 4, 2, 4);
         chk_vec($sformatf("abort c=%0d", c), v1, e);
         if (c == 11) chk("late_bus_data", {24'd0, mem_data1}, 32'h55);
         else if (e[16]) chk($sformatf("abort_data c=%0d", c), {24'd0, mem_data1}, {24'd0, exp_data(c, 11)});
         ovr_en  = (c == 9 || c == 10);
         ovr_val = (c == 9) ? 8'hAA : 8'h55;
         if (c == 85) reset = 1'b0;
         @(negedge clk);
      end
      chk_vec("abort_reset", v1, exp_vec(0, 4, 2, 4));
      chk("abort_mdata", {24'd0, mem_data1}, 32'h00);
      reset = 1'b1;
      mw1 = 0; dn1 = 0;
      for (int c = 0; c < 120; c++) begin
         mw1 += int'(mem_wr1); dn1 += int'(done1);
         @(negedge clk);
      end
      chk("abort_no_mem_wr", mw1, 0);
      chk("abort_no_done", dn1, 0);
      chk_vec("abort_idle", v1, exp_vec(0, 4, 2, 4));

      // start held high: back-to-back sweeps every 112 cycles.
      start = 1'b1;
      @(negedge clk);
      mw1 = 0;
      for (int c = 1; c <= 338; c++) begin
         int cc;
         cc = (c > 336) ? 0 : ((c - 1) % 112) + 1;
         e = exp_vec(cc, 4, 2, 4);
         chk_vec($sformatf("b2b c=%0d", c), v1, e);
         if (e[16]) chk($sformatf("b2b_data c=%0d", c), {24'd0, mem_data1}, {24'd0, exp_data(cc, 11)});
         mw1 += int'(mem_wr1);
         start = (c < 300);
         @(negedge clk);
      end
      chk("b2b_mem_wr_count", mw1, 30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
